// File: rtl/uart_pkg.sv
// Shared UART receive types and default frame constants.
package uart_pkg;

  localparam int UART_OVERSAMPLE = 16;
  localparam int UART_DATA_BITS  = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_rx_state_t;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous serial line; resets to idle (1).
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic rx,
  output logic rx_s
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      meta <= rx;
      rx_s <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive control FSM: start qualification, mid-bit sampling, stop check.
// Optional parity bit compiled in with `define UART_RX_PARITY_EN.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = UART_OVERSAMPLE,
  parameter int DATA_BITS  = UART_DATA_BITS,
  parameter int PARITY_ODD = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic rx,
  output logic sipo_data,
  output logic sipo_shift,
  output logic rx_done,
  output logic frame_err,
  output logic parity_err,
  output logic busy
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [TW-1:0] T_MID  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] T_END  = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);
  localparam logic          PODD   = (PARITY_ODD != 0);

  logic           rx_s;
  uart_rx_state_t state, state_nxt;
  logic [TW-1:0]  tcnt, tcnt_nxt;
  logic [BW-1:0]  bcnt, bcnt_nxt;
  logic           armed, armed_nxt;
  logic           shift_nxt, done_nxt, start_ok, last;

  uart_rx_sync u_sync (
    .clk  (clk),
    .rst  (rst),
    .rx   (rx),
    .rx_s (rx_s)
  );

  assign last = (tcnt == T_END);

  always_comb begin
    state_nxt = state;
    tcnt_nxt  = tcnt;
    bcnt_nxt  = bcnt;
    armed_nxt = armed;
    shift_nxt = 1'b0;
    done_nxt  = 1'b0;
    start_ok  = 1'b0;
    if (tick) begin
      case (state)
        IDLE: begin
          tcnt_nxt = '0;
          if (rx_s)       armed_nxt = 1'b1;
          else if (armed) state_nxt = START;
        end
        START: begin
          if (tcnt == T_MID) begin
            tcnt_nxt  = '0;
            bcnt_nxt  = '0;
            start_ok  = ~rx_s;
            // line back high at mid start bit: treat as a glitch
            state_nxt = rx_s ? IDLE : DATA;
          end else begin
            tcnt_nxt = tcnt + 1'b1;
          end
        end
        DATA: begin
          if (last) begin
            tcnt_nxt  = '0;
            bcnt_nxt  = bcnt + 1'b1;
            shift_nxt = 1'b1;
            if (bcnt == B_LAST) begin
`ifdef UART_RX_PARITY_EN
              state_nxt = PARITY;
`else
              state_nxt = STOP;
`endif
            end
          end else begin
            tcnt_nxt = tcnt + 1'b1;
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (last) begin
            tcnt_nxt  = '0;
            state_nxt = STOP;
          end else begin
            tcnt_nxt = tcnt + 1'b1;
          end
        end
`endif
        STOP: begin
          if (last) begin
            tcnt_nxt  = '0;
            done_nxt  = 1'b1;
            // a low stop bit disarms until the line is seen idle again
            if (!rx_s) armed_nxt = 1'b0;
            state_nxt = IDLE;
          end else begin
            tcnt_nxt = tcnt + 1'b1;
          end
        end
        default: begin
          tcnt_nxt  = '0;
          state_nxt = IDLE;
        end
      endcase
    end
  end

`ifdef UART_RX_PARITY_EN
  logic par_acc, par_bad;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      par_acc <= 1'b0;
      par_bad <= 1'b0;
    end else begin
      if (start_ok)       par_acc <= 1'b0;
      else if (shift_nxt) par_acc <= par_acc ^ rx_s;
      if (tick && state == PARITY && last)
        par_bad <= par_acc ^ rx_s ^ PODD;
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      tcnt       <= '0;
      bcnt       <= '0;
      armed      <= 1'b1;
      sipo_data  <= 1'b0;
      sipo_shift <= 1'b0;
      rx_done    <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nxt;
      tcnt       <= tcnt_nxt;
      bcnt       <= bcnt_nxt;
      armed      <= armed_nxt;
      sipo_shift <= shift_nxt;
      rx_done    <= done_nxt;
      busy       <= (state_nxt != IDLE);
      if (shift_nxt) sipo_data <= rx_s;
      if (done_nxt) begin
        frame_err <= ~rx_s;
`ifdef UART_RX_PARITY_EN
        parity_err <= par_bad;
`endif
      end
`ifndef UART_RX_PARITY_EN
      parity_err <= 1'b0 & PODD;
`endif
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed self-checking bench for uart_rx_ctrl (8 data bits, 16x oversampling).
module tb_uart_rx_ctrl;
  import uart_pkg::*;

  localparam int OS = 16;

  logic clk = 1'b0, rst = 1'b1, tick = 1'b0, rx = 1'b1;
  logic sipo_data, sipo_shift, rx_done, frame_err, parity_err, busy;

  int n_checks = 0, n_fail = 0;

  // observation state, written only by the monitor
  int         shifts = 0, dones = 0, ferrs = 0, perrs = 0;
  logic [7:0] sipo = '0, done_byte = '0, bitlog = '0;

  uart_rx_ctrl #(.OVERSAMPLE(OS), .DATA_BITS(8), .PARITY_ODD(0)) dut (
    .clk        (clk),
    .rst        (rst),
    .tick       (tick),
    .rx         (rx),
    .sipo_data  (sipo_data),
    .sipo_shift (sipo_shift),
    .rx_done    (rx_done),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;
  always @(negedge clk) tick = ~tick;

  // SIPO model: LSB first, new bit enters at the top
  always @(negedge clk) begin
    if (sipo_shift) begin
      shifts = shifts + 1;
      sipo   = {sipo_data, sipo[7:1]};
      bitlog = {bitlog[6:0], sipo_data};
    end
    if (rx_done) begin
      dones     = dones + 1;
      done_byte = sipo;
      if (frame_err)  ferrs = ferrs + 1;
      if (parity_err) perrs = perrs + 1;
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic wait_ticks(input int n);
    int c = 0;
    while (c < n) begin
      @(posedge clk);
      if (tick) c++;
    end
    #1;
  endtask

  // leaves rx at the stop-bit level; caller decides what follows
  task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic pbit);
    rx = 1'b0;
    wait_ticks(OS);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      wait_ticks(OS);
    end
`ifdef UART_RX_PARITY_EN
    rx = pbit;
    wait_ticks(OS);
`else
    if (pbit) rx = 1'b0;
`endif
    rx = stop_bit;
    wait_ticks(OS);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop_bit;
    int         exp_shifts;
    int         exp_dones;
    logic       exp_ferr;
    logic [7:0] exp_bits;
  } vec_t;

  initial begin
    vec_t vt[5];
    int s0, d0, f0, p0;

    // exp_bits: order sampled on sipo_data, first bit in the MSB
    vt[0] = '{8'hA3, 1'b1, 8, 1, 1'b0, 8'b1100_0101};
    vt[1] = '{8'h3C, 1'b1, 8, 1, 1'b0, 8'b0011_1100};
    vt[2] = '{8'h55, 1'b0, 8, 1, 1'b1, 8'b1010_1010};
    vt[3] = '{8'hFF, 1'b1, 8, 1, 1'b0, 8'b1111_1111};
    vt[4] = '{8'h01, 1'b1, 8, 1, 1'b0, 8'b1000_0000};

    repeat (3) @(posedge clk);
    #1;
    check("reset sipo_data",  {31'd0, sipo_data},  32'd0);
    check("reset sipo_shift", {31'd0, sipo_shift}, 32'd0);
    check("reset rx_done",    {31'd0, rx_done},    32'd0);
    check("reset frame_err",  {31'd0, frame_err},  32'd0);
    check("reset parity_err", {31'd0, parity_err}, 32'd0);
    check("reset busy",       {31'd0, busy},       32'd0);
    @(negedge clk) rst = 1'b0;
    wait_ticks(4);

    for (int i = 0; i < 5; i++) begin
      s0 = shifts; d0 = dones;
      send_frame(vt[i].data, vt[i].stop_bit, ^vt[i].data);
      rx = 1'b1;
      wait_ticks(OS);
      check($sformatf("vec%0d shifts", i), shifts - s0, vt[i].exp_shifts);
      check($sformatf("vec%0d dones", i),  dones - d0,  vt[i].exp_dones);
      check($sformatf("vec%0d bits", i),   {24'd0, bitlog}, {24'd0, vt[i].exp_bits});
      check($sformatf("vec%0d byte", i),   {24'd0, done_byte}, {24'd0, vt[i].data});
      check($sformatf("vec%0d frame_err", i), {31'd0, frame_err}, {31'd0, vt[i].exp_ferr});
      check($sformatf("vec%0d parity_err", i), {31'd0, parity_err}, 32'd0);
      check($sformatf("vec%0d busy", i), {31'd0, busy}, 32'd0);
    end

    // glitch start: low for 4 ticks only
    s0 = shifts; d0 = dones;
    rx = 1'b0;
    wait_ticks(3);
    check("glitch busy rises", {31'd0, busy}, 32'd1);
    wait_ticks(1);
    rx = 1'b1;
    wait_ticks(20);
    check("glitch shifts", shifts - s0, 0);
    check("glitch dones", dones - d0, 0);
    check("glitch busy idle", {31'd0, busy}, 32'd0);

    // low stop bit followed by a held break
    s0 = shifts; d0 = dones; f0 = ferrs;
    send_frame(8'h55, 1'b0, 1'b0);
    wait_ticks(40);
    check("break shifts", shifts - s0, 8);
    check("break dones", dones - d0, 1);
    check("break ferr count", ferrs - f0, 1);
    check("break frame_err", {31'd0, frame_err}, 32'd1);
    check("break busy", {31'd0, busy}, 32'd0);
    rx = 1'b1;
    wait_ticks(OS);
    send_frame(8'hA5, 1'b1, ^8'hA5);
    rx = 1'b1;
    wait_ticks(OS);
    check("after break dones", dones - d0, 2);
    check("after break byte", {24'd0, done_byte}, 32'hA5);
    check("after break frame_err", {31'd0, frame_err}, 32'd0);

    // back-to-back frames, no idle gap
    s0 = shifts; d0 = dones; f0 = ferrs;
    send_frame(8'h00, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0);
    rx = 1'b1;
    wait_ticks(OS);
    check("b2b shifts", shifts - s0, 16);
    check("b2b dones", dones - d0, 2);
    check("b2b ferr count", ferrs - f0, 0);
    check("b2b byte", {24'd0, done_byte}, 32'hFF);

    // reset after the 3rd shift of 0x3C
    s0 = shifts; d0 = dones;
    rx = 1'b0;
    wait_ticks(OS);
    for (int i = 0; i < 3; i++) begin
      rx = (i == 2);
      wait_ticks(OS);
    end
    check("midrst shifts before", shifts - s0, 3);
    check("midrst busy before", {31'd0, busy}, 32'd1);
    rx = 1'b1;
    @(negedge clk) rst = 1'b1;
    #1;
    check("midrst sipo_data", {31'd0, sipo_data}, 32'd0);
    check("midrst busy", {31'd0, busy}, 32'd0);
    check("midrst rx_done", {31'd0, rx_done}, 32'd0);
    check("midrst frame_err", {31'd0, frame_err}, 32'd0);
    @(negedge clk) rst = 1'b0;
    wait_ticks(3 * OS);
    check("midrst no more shifts", shifts - s0, 3);
    check("midrst no done", dones - d0, 0);
    send_frame(8'h3C, 1'b1, ^8'h3C);
    rx = 1'b1;
    wait_ticks(OS);
    check("post rst dones", dones - d0, 1);
    check("post rst byte", {24'd0, done_byte}, 32'h3C);

`ifdef UART_RX_PARITY_EN
    d0 = dones; p0 = perrs;
    send_frame(8'h07, 1'b1, 1'b1);
    rx = 1'b1;
    wait_ticks(OS);
    check("parity good dones", dones - d0, 1);
    check("parity good flag", {31'd0, parity_err}, 32'd0);
    send_frame(8'h07, 1'b1, 1'b0);
    rx = 1'b1;
    wait_ticks(OS);
    check("parity bad dones", dones - d0, 2);
    check("parity bad flag", {31'd0, parity_err}, 32'd1);
    check("parity err count", perrs - p0, 1);
`else
    p0 = perrs;
    check("no parity errors", p0, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_ctrl.md
# uart_rx_ctrl

Receive-side control FSM for the UART. It synchronises the raw serial line, detects and qualifies the start bit using a 16× oversampling tick, and samples each data bit at mid-bit. Each sampled bit goes to the downstream 8-bit serial-in/parallel-out register as a one-cycle `sipo_shift` pulse, with the bit on `sipo_data`, LSB first. It then checks the stop bit and flags frame completion.

## Interface
- `OVERSAMPLE`, 16: ticks per bit period; even, ≥ 4.
- `DATA_BITS`, 8: data bits per frame; must equal downstream SIPO width.
- `PARITY_ODD`, 0: 0 = even parity, 1 = odd parity. Used only when parity is compiled in.

- `clk` in 1: system clock; single clock domain.
- `rst` in 1: asynchronous, active-high reset.
- `tick` in 1: one-`clk` pulse at OVERSAMPLE × baud rate.
- `rx` in 1: raw serial line; asynchronous; idles high.
- `sipo_data` out 1: sampled data bit; valid while `sipo_shift` = 1.
- `sipo_shift` out 1: one-cycle shift strobe to the SIPO.
- `rx_done` out 1: one-cycle pulse at end of frame.
- `frame_err` out 1: stop bit sampled low. Updated with `rx_done`, held until the next `rx_done`.
- `parity_err` out 1: parity mismatch. Updated with `rx_done`; tied to 0 without the macro.
- `busy` out 1: high in any state other than IDLE.

## Operation
- `rx` passes through a 2-flop synchroniser, `rx_s`. Both flops reset to 1.
- Tick counter `tcnt` has width $clog2(OVERSAMPLE). Bit counter `bcnt` has width $clog2(DATA_BITS+1).
- All state advances happen only on cycles where `tick` = 1. With no tick, everything holds.
- States and transitions:
  - **IDLE**: `tcnt` = 0. If `armed` and `rx_s` = 0, go to START. `armed` sets when `rx_s` = 1 is seen in IDLE. It clears on a frame error, so a held-low break does not restart reception until the line returns high.
  - **START**: count ticks. At `tcnt` = OVERSAMPLE/2−1 (mid start bit):
    - `rx_s` = 0 → DATA, with `tcnt` = 0 and `bcnt` = 0.
    - `rx_s` = 1 → IDLE. This is glitch rejection; no outputs change.
  - **DATA**: at `tcnt` = OVERSAMPLE−1:
    - Register `sipo_data` ← `rx_s` and pulse `sipo_shift` for exactly one `clk`.
    - Increment `bcnt` and clear `tcnt`.
    - When `bcnt` reaches DATA_BITS, go to STOP, or to PARITY when compiled in.
  - **PARITY** (macro only): at `tcnt` = OVERSAMPLE−1, sample the parity bit, then go to STOP.
  - **STOP**: at `tcnt` = OVERSAMPLE−1:
    - Pulse `rx_done`.
    - `frame_err` ← ~`rx_s`.
    - `parity_err` ← result of the parity check.
    - Go to IDLE. This happens at mid stop bit, so back-to-back frames are accepted.
- `rx_done` pulses even on an error. The consumer qualifies the byte with the error flags.
- Reset mid-frame: immediate return to IDLE with counters at 0. No `rx_done` and no further `sipo_shift` for the aborted frame.

## Timing
- Reset values:
  - `sipo_data` = 0, `sipo_shift` = 0, `rx_done` = 0, `frame_err` = 0, `parity_err` = 0, `busy` = 0.
  - State = IDLE, `armed` = 1.
- All outputs are registered.
- `sipo_data` and `sipo_shift` change on the same edge. The SIPO captures the bit on the following `clk` edge.
- Synchroniser latency is 2 `clk`. The start edge is recognised on the first tick after `rx_s` falls.
- Data sampling points fall at tick OVERSAMPLE/2 + k·OVERSAMPLE after the start is detected, for k = 1..DATA_BITS.
- `rx_done` occurs at least OVERSAMPLE ticks after the last `sipo_shift`, so the SIPO output is stable when `rx_done` is asserted.
- If `rx_done` and a new start edge fall on the same tick: `rx_done` is issued, and the start is seen on the next tick in IDLE.

## Configuration
- `UART_RX_PARITY_EN`, when defined:
  - Adds the PARITY state, one parity bit between the data and stop bits.
  - A running XOR `par_acc` accumulates the data bits.
  - `parity_err` ← (`par_acc` ^ sampled bit ^ PARITY_ODD) != 0.
- When undefined:
  - No PARITY state or accumulator.
  - `parity_err` is a constant 0.
  - Frame is start + DATA_BITS + stop.

## Structure
- Shared package `uart_pkg` holds:
  - the state enum `uart_rx_state_t` (IDLE, START, DATA, PARITY, STOP);
  - the default constants `UART_OVERSAMPLE` = 16 and `UART_DATA_BITS` = 8.
- Sub-module `uart_rx_sync`: a 2-flop synchroniser with reset value 1. The FSM, counters and output registers stay in `uart_rx_ctrl`.

## Test plan
- **Byte 0xA3**, 8N1, OVERSAMPLE 16: exactly 8 `sipo_shift` pulses with `sipo_data` = 1,1,0,0,0,1,0,1. Then `rx_done` once, `frame_err` = 0, and the SIPO holds 0xA3.
- **Glitch start**: `rx` low for 4 ticks, then high → no `sipo_shift`, no `rx_done`, `busy` returns to 0.
- **Stop bit low** for byte 0x55: `rx_done` with `frame_err` = 1. With `rx` then held low for 40 ticks, there is no new frame until `rx` goes high and falls again.
- **Back-to-back** 0x00 then 0xFF with no idle gap: two `rx_done` pulses, 16 shifts total, both `frame_err` = 0.
- **Reset mid-frame**: `rst` pulsed after the 3rd `sipo_shift` → outputs at reset values, no `rx_done`. The next clean frame 0x3C is received correctly.
- **With `UART_RX_PARITY_EN`, PARITY_ODD = 0**: byte 0x07 with parity bit 1 → `parity_err` = 0. The same byte with parity bit 0 → `parity_err` = 1.
